ps2_command_decoder: RTL and testbench

PS2_COMMAND_DECODER -- requirements
Module: ps2_command_decoder

---
 rtl/ps2_pkg.sv | 48 ++++
 rtl/ps2_clk_filter.sv | 56 +++++
 rtl/ps2_command_decoder.sv | 168 ++++++++++++++++
 tb/tb_ps2_command_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 command decoder: command codes, scan codes,
// frame FSM states and the scan-code-to-command lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    localparam logic [1:0] CMD_IDLE   = 2'b00;
    localparam logic [1:0] CMD_LEFT   = 2'b01;
    localparam logic [1:0] CMD_RIGHT  = 2'b10;
    localparam logic [1:0] CMD_ROTATE = 2'b11;

    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_BRK       = 8'hF0;
    localparam logic [7:0] SC_LEFT      = 8'h1C;
    localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT     = 8'h23;
    localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
    localparam logic [7:0] SC_ROT       = 8'h1D;
    localparam logic [7:0] SC_ROT_EXT   = 8'h75;

    // CMD_IDLE doubles as "unmapped": no key maps to the idle command.
    function automatic logic [1:0] classify(input logic [7:0] code, input logic ext);
        logic [1:0] cmd;
        cmd = CMD_IDLE;
        if (ext) begin
            case (code)
                SC_LEFT_EXT:  cmd = CMD_LEFT;
                SC_RIGHT_EXT: cmd = CMD_RIGHT;
                SC_ROT_EXT:   cmd = CMD_ROTATE;
                default:      cmd = CMD_IDLE;
            endcase
        end else begin
            case (code)
                SC_LEFT:  cmd = CMD_LEFT;
                SC_RIGHT: cmd = CMD_RIGHT;
                SC_ROT:   cmd = CMD_ROTATE;
                default:  cmd = CMD_IDLE;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the PS/2 lines, deglitches ps2_clk and emits a one-cycle
// strobe on each falling edge of the filtered clock.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_stb,
    output logic data_sync
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        cnt_d       = '0;
        // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    assign fall_stb  = fall_q;
    assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_command_decoder.sv
// PS/2 keyboard receiver that turns make/break scan codes into a held game command.
// Define PS2_PARITY_CHECK_EN to discard frames that fail the odd-parity check.
module ps2_command_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] keyboard_signal,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic fall_stb;
    logic data_sync;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (data_sync_unused_guard(ps2_data)),
        .fall_stb (fall_stb),
        .data_sync(data_sync)
    );

    function automatic logic data_sync_unused_guard(input logic d);
        return d;
    endfunction

    frame_state_e     state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             frame_err_q, frame_err_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [1:0]       kbd_q, kbd_d;
    logic             timeout;
    logic             parity_ok;
    logic [1:0]       cmd;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    assign timeout = (state_q != ST_IDLE) && !fall_stb && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign cmd     = classify(byte_data_q, ext_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            kbd_q        <= CMD_IDLE;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            kbd_q        <= kbd_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end

    always_comb begin
        parity_d = parity_q;
        if (fall_stb && state_q == ST_PARITY) parity_d = data_sync;
    end
`endif

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (fall_stb) begin
            case (state_q)
                ST_IDLE:   if (!data_sync) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_d        = (state_q == ST_IDLE || fall_stb) ? '0 : tmo_q + TMO_W'(1);
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = timeout;
        ext_d        = ext_q;
        brk_d        = brk_q;
        kbd_d        = kbd_q;

        if (fall_stb) begin
            case (state_q)
                ST_IDLE: bit_cnt_d = '0;
                ST_DATA: begin
                    shift_d   = {data_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_STOP: begin
                    if (data_sync && parity_ok) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Prefix bytes arm flags; any other byte is classified and consumes them.
        if (byte_valid_q) begin
            if (byte_data_q == SC_EXT) begin
                ext_d = 1'b1;
            end else if (byte_data_q == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (cmd != CMD_IDLE) begin
                    if (!brk_q)            kbd_d = cmd;
                    else if (cmd == kbd_q) kbd_d = CMD_IDLE;
                end
            end
        end else if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    assign keyboard_signal = kbd_q;
    assign byte_valid      = byte_valid_q;
    assign byte_data       = byte_data_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Directed bench for ps2_command_decoder: table of scan-code frames plus
// hand-written timeout and mid-frame reset sequences.
module tb_ps2_command_decoder;
    localparam int HALF    = 20;
    localparam int TIMEOUT = 600;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] keyboard_signal;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    ps2_command_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .keyboard_signal(keyboard_signal),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        logic [1:0] exp_kbd;
        bit         exp_ok;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   bv_cnt   = 0;
    int   fe_cnt   = 0;
    int   chg_cnt  = 0;
    logic [7:0] bv_last = 8'h00;
    logic [1:0] kbd_mon = 2'b00;

    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) begin
                bv_cnt  = bv_cnt + 1;
                bv_last = byte_data;
            end
            if (frame_err) fe_cnt = fe_cnt + 1;
        end
        if (keyboard_signal != kbd_mon) begin
            chg_cnt = chg_cnt + 1;
            kbd_mon = keyboard_signal;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks = n_checks + 1;
        if (actual == expected) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] code, input bit bad_par);
        logic par;
        par = ~(^code) ^ bad_par;
        return {1'b1, par, code, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] code);
        send_bits(make_frame(code, 1'b0), 11);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bv0, fe0, chg0;
        logic [1:0] prev_kbd;
        logic [7:0] last_good;

        vecs.push_back('{8'h1C, 1'b0, 2'b01, 1'b1});
        vecs.push_back('{8'hE0, 1'b0, 2'b01, 1'b1});
        vecs.push_back('{8'h75, 1'b0, 2'b11, 1'b1});
        vecs.push_back('{8'hE0, 1'b0, 2'b11, 1'b1});
        vecs.push_back('{8'hF0, 1'b0, 2'b11, 1'b1});
        vecs.push_back('{8'h75, 1'b0, 2'b00, 1'b1});
        vecs.push_back('{8'h75, 1'b0, 2'b00, 1'b1});
        vecs.push_back('{8'h1C, 1'b0, 2'b01, 1'b1});
        vecs.push_back('{8'h23, 1'b0, 2'b10, 1'b1});
        vecs.push_back('{8'hF0, 1'b0, 2'b10, 1'b1});
        vecs.push_back('{8'h1C, 1'b0, 2'b10, 1'b1});
        vecs.push_back('{8'h23, 1'b0, 2'b10, 1'b1});
        vecs.push_back('{8'h23, 1'b0, 2'b10, 1'b1});
        vecs.push_back('{8'h6B, 1'b0, 2'b10, 1'b1});
        vecs.push_back('{8'hF0, 1'b0, 2'b10, 1'b1});
        vecs.push_back('{8'h23, 1'b0, 2'b00, 1'b1});
        vecs.push_back('{8'h1C, 1'b1, PAR_ON ? 2'b00 : 2'b01, !PAR_ON});
        vecs.push_back('{8'hF0, 1'b0, PAR_ON ? 2'b00 : 2'b01, 1'b1});
        vecs.push_back('{8'h1C, 1'b0, 2'b00, 1'b1});
        vecs.push_back('{8'hE0, 1'b0, 2'b00, 1'b1});
        vecs.push_back('{8'h6B, 1'b0, 2'b01, 1'b1});
        vecs.push_back('{8'hE0, 1'b0, 2'b01, 1'b1});
        vecs.push_back('{8'hF0, 1'b0, 2'b01, 1'b1});
        vecs.push_back('{8'h6B, 1'b0, 2'b00, 1'b1});

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_kbd", keyboard_signal, 0);
        check("reset_byte_valid", byte_valid, 0);
        check("reset_byte_data", byte_data, 0);
        check("reset_frame_err", frame_err, 0);
        @(posedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        prev_kbd  = 2'b00;
        last_good = 8'h00;
        foreach (vecs[i]) begin
            bv0 = bv_cnt; fe0 = fe_cnt; chg0 = chg_cnt;
            send_bits(make_frame(vecs[i].code, vecs[i].bad_par), 11);
            @(negedge clk);
            if (vecs[i].exp_ok) last_good = vecs[i].code;
            $display("vec %0d: code %02h bad_par %0d -> kbd %02b valid %0d err %0d",
                     i, vecs[i].code, vecs[i].bad_par, keyboard_signal, bv_cnt - bv0, fe_cnt - fe0);
            check($sformatf("vec%0d_valid_pulses", i), bv_cnt - bv0, vecs[i].exp_ok ? 1 : 0);
            check($sformatf("vec%0d_err_pulses", i), fe_cnt - fe0, vecs[i].exp_ok ? 0 : 1);
            if (vecs[i].exp_ok) check($sformatf("vec%0d_pulse_data", i), bv_last, vecs[i].code);
            check($sformatf("vec%0d_byte_data_held", i), byte_data, last_good);
            check($sformatf("vec%0d_kbd", i), keyboard_signal, vecs[i].exp_kbd);
            check($sformatf("vec%0d_kbd_changes", i), chg_cnt - chg0,
                  (vecs[i].exp_kbd != prev_kbd) ? 1 : 0);
            prev_kbd = vecs[i].exp_kbd;
        end

        // Break prefix, then a truncated frame: the abort must also drop the prefix.
        send_byte(8'hF0);
        bv0 = bv_cnt; fe0 = fe_cnt;
        send_bits(make_frame(8'h23, 1'b0), 5);
        repeat (TIMEOUT + 100) @(posedge clk);
        @(negedge clk);
        $display("timeout: err %0d valid %0d kbd %02b", fe_cnt - fe0, bv_cnt - bv0, keyboard_signal);
        check("timeout_err_pulse", fe_cnt - fe0, 1);
        check("timeout_no_valid", bv_cnt - bv0, 0);
        check("timeout_kbd", keyboard_signal, 0);
        send_byte(8'h23);
        @(negedge clk);
        $display("after timeout: 23 -> kbd %02b", keyboard_signal);
        check("after_timeout_kbd", keyboard_signal, 2);
        check("after_timeout_data", byte_data, 8'h23);

        // Reset in the middle of a frame while RIGHT is held.
        send_bits(make_frame(8'h1C, 1'b0), 4);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        $display("mid-frame reset: kbd %02b valid %0d data %02h err %0d",
                 keyboard_signal, byte_valid, byte_data, frame_err);
        check("midrst_kbd", keyboard_signal, 0);
        check("midrst_byte_valid", byte_valid, 0);
        check("midrst_byte_data", byte_data, 0);
        check("midrst_frame_err", frame_err, 0);
        repeat (5) @(posedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        bv0 = bv_cnt; fe0 = fe_cnt;
        send_byte(8'h1D);
        @(negedge clk);
        $display("after reset: 1D -> kbd %02b data %02h", keyboard_signal, byte_data);
        check("after_rst_kbd", keyboard_signal, 3);
        check("after_rst_data", bv_last, 8'h1D);
        check("after_rst_valid", bv_cnt - bv0, 1);
        check("after_rst_no_err", fe_cnt - fe0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
